// File: rtl/cbd_sampler_pkg.sv
// Shared constants, FSM encoding and sizing helpers for the centered-binomial sampler.
// KYBER_ETA1/KYBER_ETA2 are the two CBD widths a Kyber parameter set draws from.
package cbd_sampler_pkg;

  localparam int KYBER_N           = 256;
  localparam int KYBER_SPOLY_WIDTH = 3;
  localparam int KYBER_ETA1        = 3;
  localparam int KYBER_ETA2        = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } cbd_state_e;

  // Number of input words that exactly cover one polynomial's worth of CBD bits.
  function automatic int cbd_word_limit(input int eta, input int in_width);
    return (KYBER_N * 2 * eta) / in_width;
  endfunction

endpackage

// File: rtl/cbd_coeff.sv
// Combinational CBD kernel: popcount of the low ETA bits minus popcount of the high ETA bits,
// returned as a KYBER_SPOLY_WIDTH-bit two's complement value in -ETA..+ETA.
module cbd_coeff
  import cbd_sampler_pkg::*;
#(
  parameter int ETA = 2
) (
  input  logic [2*ETA-1:0]             bits,
  output logic [KYBER_SPOLY_WIDTH-1:0] coeff
);

  localparam int W = KYBER_SPOLY_WIDTH;

  logic [W-1:0] a_sum;
  logic [W-1:0] b_sum;

  always_comb begin
    a_sum = '0;
    b_sum = '0;
    for (int i = 0; i < ETA; i++) begin
      a_sum = a_sum + W'(bits[i]);
      b_sum = b_sum + W'(bits[ETA+i]);
    end
  end

  // Modular subtraction already yields the correct two's complement pattern.
  assign coeff = a_sum - b_sum;

endmodule

// File: rtl/cbd_sampler.sv
// Centered-binomial sampler: packs PRF words into an LSB-first bit buffer and emits one
// small coefficient per handshake, KYBER_N per polynomial, then pulses done.
module cbd_sampler
  import cbd_sampler_pkg::*;
#(
  parameter int ETA       = KYBER_ETA2,
  parameter int IN_WIDTH  = 32,
  parameter int BUF_WIDTH = 48
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [IN_WIDTH-1:0]          in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [KYBER_SPOLY_WIDTH-1:0] coeff_out,
  output logic                         coeff_valid,
  input  logic                         coeff_ready,
  output logic [7:0]                   coeff_idx,
  output logic                         busy,
  output logic                         done
);

  localparam int STEP   = 2 * ETA;
  localparam int WORDS  = cbd_word_limit(ETA, IN_WIDTH);
  localparam int CNT_W  = $clog2(BUF_WIDTH + 1);
  localparam int WCNT_W = $clog2(WORDS + 1);

  localparam logic [CNT_W-1:0]  CNT_STEP   = CNT_W'(STEP);
  localparam logic [CNT_W-1:0]  CNT_IN     = CNT_W'(IN_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_ROOM   = CNT_W'(BUF_WIDTH - IN_WIDTH);
  localparam logic [WCNT_W-1:0] WORD_LIMIT = WCNT_W'(WORDS);
  localparam logic [7:0]        LAST_IDX   = 8'(KYBER_N - 1);

  if (ETA != 2 && ETA != 3) begin : g_bad_eta
    $error("cbd_sampler: ETA must be 2 or 3");
  end
  if (BUF_WIDTH < IN_WIDTH + STEP - 1) begin : g_bad_buf
    $error("cbd_sampler: BUF_WIDTH too small for IN_WIDTH and ETA");
  end

  cbd_state_e          state_reg;
  logic [BUF_WIDTH-1:0] bits_reg;
  logic [BUF_WIDTH-1:0] bits_shift;
  logic [BUF_WIDTH-1:0] bits_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic [CNT_W-1:0]    cnt_shift;
  logic [CNT_W-1:0]    cnt_next;
  logic [WCNT_W-1:0]   word_cnt_reg;
  logic [7:0]          idx_reg;
  logic                done_reg;
  logic                run;
  logic                accept;
  logic                take;

  assign run         = (state_reg == ST_RUN);
  assign in_ready    = run && (cnt_reg <= CNT_ROOM) && (word_cnt_reg < WORD_LIMIT);
  assign coeff_valid = run && (cnt_reg >= CNT_STEP);
  assign accept      = in_valid && in_ready;
  assign take        = coeff_valid && coeff_ready;

  // Consume first, then append the new word above whatever bits remain after the shift.
  always_comb begin
    bits_shift = take ? (bits_reg >> STEP) : bits_reg;
    cnt_shift  = take ? (cnt_reg - CNT_STEP) : cnt_reg;
    bits_next  = bits_shift;
    cnt_next   = cnt_shift;
    if (accept) begin
      bits_next = bits_shift | (BUF_WIDTH'(in_data) << cnt_shift);
      cnt_next  = cnt_shift + CNT_IN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      bits_reg     <= '0;
      cnt_reg      <= '0;
      word_cnt_reg <= '0;
      idx_reg      <= '0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg    <= ST_RUN;
            bits_reg     <= '0;
            cnt_reg      <= '0;
            word_cnt_reg <= '0;
            idx_reg      <= '0;
          end
        end
        ST_RUN: begin
          bits_reg <= bits_next;
          cnt_reg  <= cnt_next;
          if (accept) begin
            word_cnt_reg <= word_cnt_reg + WCNT_W'(1);
          end
          if (take) begin
            if (idx_reg == LAST_IDX) begin
              state_reg <= ST_IDLE;
              idx_reg   <= '0;
              done_reg  <= 1'b1;
            end else begin
              idx_reg <= idx_reg + 8'd1;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  cbd_coeff #(.ETA(ETA)) u_coeff (
    .bits  (bits_reg[STEP-1:0]),
    .coeff (coeff_out)
  );

  assign coeff_idx = idx_reg;
  assign busy      = run;
  assign done      = done_reg;

endmodule

// File: tb/tb_cbd_sampler.sv
// Bench for cbd_sampler: one ETA=2 and one ETA=3 instance driven with directed and random
// PRF words, every coefficient compared with a bit-level SamplePolyCBD reference.
module tb_cbd_sampler;
  import cbd_sampler_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_s       [2];
  logic [31:0] in_data_s     [2];
  logic        in_valid_s    [2];
  logic        in_ready_s    [2];
  logic [2:0]  coeff_out_s   [2];
  logic        coeff_valid_s [2];
  logic        coeff_ready_s [2];
  logic [7:0]  coeff_idx_s   [2];
  logic        busy_s        [2];
  logic        done_s        [2];

  cbd_sampler #(.ETA(2), .IN_WIDTH(32), .BUF_WIDTH(48)) u2 (
    .clk(clk), .rst(rst), .start(start_s[0]), .in_data(in_data_s[0]),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .coeff_out(coeff_out_s[0]),
    .coeff_valid(coeff_valid_s[0]), .coeff_ready(coeff_ready_s[0]),
    .coeff_idx(coeff_idx_s[0]), .busy(busy_s[0]), .done(done_s[0])
  );

  cbd_sampler #(.ETA(3), .IN_WIDTH(32), .BUF_WIDTH(48)) u3 (
    .clk(clk), .rst(rst), .start(start_s[1]), .in_data(in_data_s[1]),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .coeff_out(coeff_out_s[1]),
    .coeff_valid(coeff_valid_s[1]), .coeff_ready(coeff_ready_s[1]),
    .coeff_idx(coeff_idx_s[1]), .busy(busy_s[1]), .done(done_s[1])
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] words [48];
  int          got   [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Reference: coefficient i of FIPS 203 SamplePolyCBD over the LSB-first word stream.
  function automatic int ref_coeff(input int eta, input int i);
    int a = 0;
    int b = 0;
    for (int j = 0; j < eta; j++) begin
      int ka = 2 * eta * i + j;
      int kb = 2 * eta * i + eta + j;
      a += int'(words[ka / 32][ka % 32]);
      b += int'(words[kb / 32][kb % 32]);
    end
    return a - b;
  endfunction

  function automatic int sext3(input logic [2:0] v);
    return int'($signed(v));
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 48; i++) words[i] = $urandom;
  endtask

  task automatic chk_idle_outputs(input int d, input string tag);
    chk({tag, "_in_ready"},    32'(in_ready_s[d]),    32'd0);
    chk({tag, "_coeff_valid"}, 32'(coeff_valid_s[d]), 32'd0);
    chk({tag, "_busy"},        32'(busy_s[d]),        32'd0);
    chk({tag, "_done"},        32'(done_s[d]),        32'd0);
    chk({tag, "_coeff_out"},   32'(coeff_out_s[d]),   32'd0);
    chk({tag, "_coeff_idx"},   32'(coeff_idx_s[d]),   32'd0);
  endtask

  function automatic int dut_cnt(input int d);
    return (d == 0) ? int'(u2.cnt_reg) : int'(u3.cnt_reg);
  endfunction

  // One polynomial on instance d. abort_at >= 0 resets when that index is presented.
  task automatic run_poly(input int d, input bit gap, input int abort_at,
                          input bit mid_start, input bit start_in_done);
    int  eta      = (d == 0) ? 2 : 3;
    int  limit    = (d == 0) ? 32 : 48;
    int  wptr     = 0;
    int  eptr     = 0;
    int  cyc      = 0;
    bit  pulsed   = 0;
    bit  first    = 1;
    bit  lat_chk  = 0;
    bit  aborted  = 0;
    bit  acc;
    bit  tk;

    @(posedge clk); #1;
    start_s[d] = 1'b1;
    @(posedge clk); #1;
    start_s[d] = 1'b0;
    chk("start_busy", 32'(busy_s[d]), 32'd1);
    chk("start_idx", 32'(coeff_idx_s[d]), 32'd0);

    while (eptr < 256 && cyc < 4000) begin
      cyc++;
      in_valid_s[d]    = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data_s[d]     = (wptr < limit) ? words[wptr] : $urandom;
      coeff_ready_s[d] = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
      start_s[d]       = mid_start && !pulsed && eptr == 50;
      if (start_s[d]) pulsed = 1;
      #1;
      chk("run_done_low", 32'(done_s[d]), 32'd0);
      if (wptr == limit) chk("in_ready_after_limit", 32'(in_ready_s[d]), 32'd0);
      if (coeff_valid_s[d]) begin
        chk($sformatf("coeff%0d_eta%0d", eptr, eta), 32'(sext3(coeff_out_s[d])),
            32'(ref_coeff(eta, eptr)));
        chk($sformatf("idx%0d_eta%0d", eptr, eta), 32'(coeff_idx_s[d]), 32'(eptr));
        if (abort_at >= 0 && eptr == abort_at) begin
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          start_s[d] = 1'b0;
          aborted = 1;
          break;
        end
      end
      acc = in_valid_s[d] && in_ready_s[d];
      tk  = coeff_valid_s[d] && coeff_ready_s[d];
      if (tk) got[eptr] = sext3(coeff_out_s[d]);
      lat_chk = acc && first;
      @(posedge clk); #1;
      start_s[d] = 1'b0;
      if (lat_chk) begin
        chk("first_word_latency", 32'(coeff_valid_s[d]), 32'd1);
        first = 0;
      end
      if (acc) wptr++;
      if (tk) eptr++;
    end

    if (aborted) begin
      chk_idle_outputs(d, "abort");
      chk("abort_cnt", 32'(dut_cnt(d)), 32'd0);
    end else if (cyc >= 4000) begin
      chk("timeout", 32'(eptr), 32'd256);
    end else begin
      $display("poly eta=%0d gap=%0d words=%0d coeffs=%0d cycles=%0d", eta, gap, wptr, eptr, cyc);
      chk("words_consumed", 32'(wptr), 32'(limit));
      chk("done_pulse", 32'(done_s[d]), 32'd1);
      chk("done_busy", 32'(busy_s[d]), 32'd0);
      chk("done_valid", 32'(coeff_valid_s[d]), 32'd0);
      chk("done_cnt", 32'(dut_cnt(d)), 32'd0);
      if (start_in_done) start_s[d] = 1'b1;
      @(posedge clk); #1;
      start_s[d] = 1'b0;
      chk("done_single", 32'(done_s[d]), 32'd0);
      chk("after_done_busy", 32'(busy_s[d]), 32'(start_in_done));
      if (start_in_done) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_idle_outputs(d, "post_restart_rst");
      end
    end
    in_valid_s[d]    = 1'b0;
    coeff_ready_s[d] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0;
      in_data_s[d] = '0;
      in_valid_s[d] = 1'b0;
      coeff_ready_s[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_idle_outputs(0, "reset_eta2");
    chk_idle_outputs(1, "reset_eta3");

    // Directed ETA=2 word: 0xC3 -> +2, -2, then zeros.
    for (int i = 0; i < 48; i++) words[i] = 32'h0;
    words[0] = 32'h000000C3;
    run_poly(0, 0, -1, 0, 0);
    chk("t1_idx0", 32'(got[0]), 32'(2));
    chk("t1_idx1", 32'(got[1]), 32'(-2));
    for (int i = 2; i < 8; i++) chk($sformatf("t1_idx%0d", i), 32'(got[i]), 32'd0);

    // Directed ETA=3 word: 0xE07 -> +3, -3; coefficient 5 straddles words 0/1.
    fill_random();
    words[0] = 32'h00000E07;
    run_poly(1, 0, -1, 0, 0);
    chk("t2_idx0", 32'(got[0]), 32'(3));
    chk("t2_idx1", 32'(got[1]), 32'(-3));
    chk("t2_idx5_straddle", 32'(got[5]),
        32'((int'(words[0][30]) + int'(words[0][31]) + int'(words[1][0]))
            - (int'(words[1][1]) + int'(words[1][2]) + int'(words[1][3]))));

    // Random full polynomials, then same streams with gapped handshakes.
    fill_random();
    run_poly(0, 0, -1, 0, 0);
    run_poly(0, 1, -1, 0, 0);
    fill_random();
    run_poly(1, 0, -1, 0, 0);
    run_poly(1, 1, -1, 0, 0);

    // Abort at index 100, then a fresh stream from idx0.
    fill_random();
    run_poly(0, 0, 100, 0, 0);
    fill_random();
    run_poly(0, 1, -1, 0, 0);

    // Start during RUN is ignored; start in the done cycle restarts.
    fill_random();
    run_poly(1, 1, -1, 1, 1);
    run_poly(0, 0, -1, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
